// File: rtl/reg_bank_seq_pkg.sv
// reg_bank_seq_pkg: op codes, FSM states and op-class helpers shared by the register bank
package reg_bank_seq_pkg;
   localparam logic [3:0] OP_NOP = 4'd0, OP_CLR = 4'd1, OP_LD  = 4'd2, OP_INC = 4'd3, OP_DEC = 4'd4;
   localparam logic [3:0] OP_SHR = 4'd5, OP_SHL = 4'd6, OP_ROR = 4'd7, OP_ROL = 4'd8, OP_ASR = 4'd9;
   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
   function automatic logic is_shift_op(input logic [3:0] op);
      return op >= OP_SHR && op <= OP_ASR;
   endfunction
   function automatic logic is_write_op(input logic [3:0] op);
      return op != OP_NOP && op <= OP_DEC;
   endfunction
endpackage

// File: rtl/reg_bank_seq_alu.sv
// reg_bank_seq_alu: combinational next-value/carry unit for single-cycle ops and 1-bit shift steps
// ports: i_op op code, i_val current value, i_din load data, i_ir/i_il serial fill bits,
//        o_val next value, o_c carry/borrow/bit shifted out
module reg_bank_seq_alu
   import reg_bank_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SATURATE   = 0
) (
   input  logic [3:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_val,
   input  logic [DATA_WIDTH-1:0] i_din,
   input  logic                  i_ir,
   input  logic                  i_il,
   output logic [DATA_WIDTH-1:0] o_val,
   output logic                  o_c
);
   localparam int W = DATA_WIDTH;
   logic w_max, w_min;
   assign w_max = &i_val;
   assign w_min = ~|i_val;
   always_comb begin
      o_val = i_val;
      o_c   = 1'b0;
      case (i_op)
         OP_CLR: o_val = '0;
         OP_LD:  o_val = i_din;
         OP_INC: begin o_val = (SATURATE != 0 && w_max) ? i_val : i_val + 1'b1; o_c = w_max; end
         OP_DEC: begin o_val = (SATURATE != 0 && w_min) ? i_val : i_val - 1'b1; o_c = w_min; end
         OP_SHR: begin o_val = {i_ir, i_val[W-1:1]};         o_c = i_val[0];   end
         OP_SHL: begin o_val = {i_val[W-2:0], i_il};         o_c = i_val[W-1]; end
         OP_ROR: begin o_val = {i_val[0], i_val[W-1:1]};     o_c = i_val[0];   end
         OP_ROL: begin o_val = {i_val[W-2:0], i_val[W-1]};   o_c = i_val[W-1]; end
         OP_ASR: begin o_val = {i_val[W-1], i_val[W-1:1]};   o_c = i_val[0];   end
         default: ;
      endcase
   end
endmodule

// File: rtl/reg_bank_seq.sv
// reg_bank_seq: register bank with addressed op port, multi-cycle shifts, two read ports, z/c flags
// ports: clk/rst sync active-high; op_valid/op_ready handshake; op/addr/din/amt/ir/il op fields;
//        rd_addr_a/b -> rd_data_a/b combinational reads; done completion pulse; flag_z/flag_c status
module reg_bank_seq
   import reg_bank_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 4,
   parameter int SATURATE   = 0,
   localparam int ADDR_W    = $clog2(NUM_REGS),
   localparam int AMT_W     = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [3:0]            op,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [AMT_W-1:0]      amt,
   input  logic                  ir,
   input  logic                  il,
   input  logic [ADDR_W-1:0]     rd_addr_a,
   input  logic [ADDR_W-1:0]     rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  done,
   output logic                  flag_z,
   output logic                  flag_c
);
   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [AMT_W-1:0]      r_cnt;
   logic [3:0]            r_op;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_ir, r_il, r_done, r_z, r_c;
   logic                  w_shift, w_in_range, w_c, w_last;
   logic [3:0]            w_op;
   logic [ADDR_W-1:0]     w_addr;
   logic [DATA_WIDTH-1:0] w_cur, w_nxt;
   // during SHIFT the ALU works on the latched op/register, otherwise on the live request
   assign w_shift    = r_state == ST_SHIFT;
   assign w_op       = w_shift ? r_op : op;
   assign w_addr     = w_shift ? r_addr : addr;
   assign w_in_range = int'(w_addr) < NUM_REGS;
   assign w_cur      = w_in_range ? r_regs[w_addr] : '0;
   assign w_last     = r_cnt == AMT_W'(1);
   reg_bank_seq_alu #(.DATA_WIDTH(DATA_WIDTH), .SATURATE(SATURATE)) u_alu (
      .i_op  (w_op),
      .i_val (w_cur),
      .i_din (din),
      .i_ir  (w_shift ? r_ir : ir),
      .i_il  (w_shift ? r_il : il),
      .o_val (w_nxt),
      .o_c   (w_c)
   );
   assign op_ready  = !w_shift && !rst;
   assign rd_data_a = int'(rd_addr_a) < NUM_REGS ? r_regs[rd_addr_a] : '0;
   assign rd_data_b = int'(rd_addr_b) < NUM_REGS ? r_regs[rd_addr_b] : '0;
   assign done      = r_done;
   assign flag_z    = r_z;
   assign flag_c    = r_c;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op    <= OP_NOP;
         r_addr  <= '0;
         r_ir    <= 1'b0;
         r_il    <= 1'b0;
         r_done  <= 1'b0;
         r_z     <= 1'b0;
         r_c     <= 1'b0;
      end else if (w_shift) begin
         r_regs[r_addr] <= w_nxt;
         r_cnt          <= r_cnt - 1'b1;
         r_done         <= w_last;
         if (w_last) begin
            r_state <= ST_IDLE;
            r_z     <= w_nxt == '0;
            r_c     <= w_c;
         end
      end else begin
         // a zero-length or out-of-range shift completes immediately like a NOP
         r_done <= op_valid && !(is_shift_op(op) && amt != '0 && w_in_range);
         if (op_valid && w_in_range) begin
            if (is_shift_op(op) && amt != '0) begin
               r_state <= ST_SHIFT;
               r_cnt   <= amt;
               r_op    <= op;
               r_addr  <= addr;
               r_ir    <= ir;
               r_il    <= il;
            end else if (is_write_op(op)) begin
               r_regs[addr] <= w_nxt;
               r_z          <= w_nxt == '0;
               r_c          <= w_c;
            end
         end
      end
   end
endmodule

// File: tb/tb_reg_bank_seq.sv
// tb_reg_bank_seq: wrap and saturate banks driven in parallel, checked against a shift-by-k reference model
module tb_reg_bank_seq;
   localparam int NR = 5;
   logic        clk = 1'b0;
   logic        rst, op_valid, ir, il;
   logic [3:0]  op, amt;
   logic [2:0]  addr, rd_addr_a, rd_addr_b;
   logic [15:0] din;
   logic        rdy [2], dn [2], fz [2], fc [2];
   logic [15:0] rda [2], rdb [2];
   int          n_chk = 0, n_fail = 0;
   logic        chk_en = 1'b0;
   logic [15:0] m_reg [2][NR];
   logic [15:0] m_start [2];
   logic        m_z [2], m_c [2], m_done;
   logic [3:0]  m_op;
   logic [2:0]  m_addr;
   logic        m_ir, m_il;
   int          busy = 0, k = 0;
   always #5 clk = ~clk;
   genvar s;
   for (s = 0; s < 2; s++) begin : g_dut
      reg_bank_seq #(.DATA_WIDTH(16), .NUM_REGS(NR), .SATURATE(s)) dut (
         .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(rdy[s]), .op(op), .addr(addr),
         .din(din), .amt(amt), .ir(ir), .il(il), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
         .rd_data_a(rda[s]), .rd_data_b(rdb[s]), .done(dn[s]), .flag_z(fz[s]), .flag_c(fc[s])
      );
   end
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // value after k single-bit steps, expressed as whole-word shifts
   function automatic logic [15:0] sh_val(input logic [15:0] v, input logic [3:0] o, input int n, input logic fr, input logic fl);
      logic [16:0] one = 17'h1;
      case (o)
         4'd5:    return (v >> n) | (fr ? ~(16'hFFFF >> n) : 16'h0);
         4'd6:    return (v << n) | (fl ? 16'((one << n) - 17'h1) : 16'h0);
         4'd7:    return (v >> n) | (v << (16 - n));
         4'd8:    return (v << n) | (v >> (16 - n));
         default: return 16'($signed(v) >>> n);
      endcase
   endfunction
   function automatic logic sh_c(input logic [15:0] v, input logic [3:0] o, input int n);
      return (o == 4'd6 || o == 4'd8) ? v[16-n] : v[n-1];
   endfunction
   task automatic model_step();
      logic [15:0] v, nv;
      logic        c;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < NR; j++) m_reg[i][j] = '0;
            m_z[i] = 0;
            m_c[i] = 0;
         end
         busy = 0;
         m_done = 0;
      end else begin
         m_done = 0;
         if (busy > 0) begin
            k++;
            busy--;
            for (int i = 0; i < 2; i++) m_reg[i][m_addr] = sh_val(m_start[i], m_op, k, m_ir, m_il);
            if (busy == 0) begin
               m_done = 1;
               for (int i = 0; i < 2; i++) begin
                  m_z[i] = m_reg[i][m_addr] == 0;
                  m_c[i] = sh_c(m_start[i], m_op, k);
               end
            end
         end else if (op_valid) begin
            if (op >= 5 && op <= 9 && amt != 0 && addr < NR) begin
               m_op = op; m_addr = addr; m_ir = ir; m_il = il; busy = amt; k = 0;
               for (int i = 0; i < 2; i++) m_start[i] = m_reg[i][addr];
            end else begin
               m_done = 1;
               if (op >= 1 && op <= 4 && addr < NR)
                  for (int i = 0; i < 2; i++) begin
                     v = m_reg[i][addr];
                     c = 0;
                     if (op == 1) nv = 0;
                     else if (op == 2) nv = din;
                     else if (op == 3) begin c = v == 16'hFFFF; nv = (i == 1 && c) ? v : v + 16'd1; end
                     else begin c = v == 0; nv = (i == 1 && c) ? v : v - 16'd1; end
                     m_reg[i][addr] = nv;
                     m_z[i] = nv == 0;
                     m_c[i] = c;
                  end
            end
         end
      end
   endtask
   initial forever begin
      @(posedge clk);
      model_step();
   end
   initial forever begin
      @(negedge clk);
      if (chk_en)
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), 16'(rdy[i]), 16'(busy == 0 && !rst));
            chk($sformatf("done%0d", i), 16'(dn[i]), 16'(m_done));
            chk($sformatf("z%0d", i), 16'(fz[i]), 16'(m_z[i]));
            chk($sformatf("c%0d", i), 16'(fc[i]), 16'(m_c[i]));
            chk($sformatf("rda%0d", i), rda[i], rd_addr_a < NR ? m_reg[i][rd_addr_a] : 16'h0);
            chk($sformatf("rdb%0d", i), rdb[i], rd_addr_b < NR ? m_reg[i][rd_addr_b] : 16'h0);
         end
   end
   task automatic issue(input logic [3:0] o, input logic [2:0] a, input logic [15:0] d, input logic [3:0] m, input logic ri, input logic li, output int n);
      logic acc;
      @(negedge clk);
      #1;
      op = o; addr = a; din = d; amt = m; ir = ri; il = li; op_valid = 1;
      n = 0;
      acc = 0;
      forever begin
         #1 acc = rdy[0];
         @(negedge clk);
         if (acc || n == 40) break;
         n++;
      end
      chk("issue_accept", 16'(acc), 16'h1);
      #1 op_valid = 0;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (!dn[0] && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("done_seen", 16'(dn[0]), 16'h1);
   endtask
   task automatic rd(input logic [2:0] a);
      rd_addr_a = a;
      #1;
   endtask
   initial begin
      int n;
      rst = 1; op_valid = 0; op = 0; addr = 0; din = 0; amt = 0; ir = 0; il = 0; rd_addr_a = 0; rd_addr_b = 0;
      repeat (2) @(negedge clk);
      #1 rst = 0;
      chk_en = 1;
      rd(0);
      chk("rst_rda", rda[0], 16'h0);
      chk("rst_done", 16'(dn[0]), 16'h0);
      chk("rst_z", 16'(fz[0]), 16'h0);
      chk("rst_ready", 16'(rdy[0]), 16'h1);
      issue(4'd2, 3'd1, 16'h1234, 0, 0, 0, n);
      chk("ld_done", 16'(dn[0]), 16'h1);
      rd(1);
      chk("ld_val", rda[0], 16'h1234);
      chk("ld_z", 16'(fz[0]), 16'h0);
      chk("ld_c", 16'(fc[0]), 16'h0);
      @(negedge clk);
      #1 rst = 1;
      #1 chk("rst_cycle_ready", 16'(rdy[0]), 16'h0);
      @(negedge clk);
      #1 rst = 0;
      rd(1);
      chk("rst_clears", rda[0], 16'h0);
      issue(4'd2, 3'd0, 16'hFFFF, 0, 0, 0, n);
      issue(4'd3, 3'd0, 16'h0, 0, 0, 0, n);
      rd(0);
      chk("inc_wrap", rda[0], 16'h0000);
      chk("inc_wrap_z", 16'(fz[0]), 16'h1);
      chk("inc_wrap_c", 16'(fc[0]), 16'h1);
      chk("inc_sat", rda[1], 16'hFFFF);
      chk("inc_sat_c", 16'(fc[1]), 16'h1);
      issue(4'd5, 3'd0, 16'h0, 0, 1, 0, n);
      chk("amt0_done", 16'(dn[0]), 16'h1);
      chk("amt0_z", 16'(fz[0]), 16'h1);
      chk("amt0_c", 16'(fc[0]), 16'h1);
      chk("amt0_val", rda[0], 16'h0);
      issue(4'd2, 3'd0, 16'h0, 0, 0, 0, n);
      issue(4'd4, 3'd0, 16'h0, 0, 0, 0, n);
      rd(0);
      chk("dec_wrap", rda[0], 16'hFFFF);
      chk("dec_wrap_c", 16'(fc[0]), 16'h1);
      chk("dec_sat", rda[1], 16'h0000);
      chk("dec_sat_z", 16'(fz[1]), 16'h1);
      issue(4'd2, 3'd2, 16'h8001, 0, 0, 0, n);
      issue(4'd7, 3'd2, 16'h0, 4, 0, 0, n);
      chk("ror_busy", 16'(rdy[0]), 16'h0);
      wait_done(n);
      chk("ror_latency", 16'(n), 16'd4);
      rd(2);
      chk("ror_val", rda[0], 16'h1800);
      chk("ror_c", 16'(fc[0]), 16'h0);
      issue(4'd2, 3'd2, 16'h8001, 0, 0, 0, n);
      issue(4'd9, 3'd2, 16'h0, 1, 0, 0, n);
      wait_done(n);
      rd(2);
      chk("asr_val", rda[0], 16'hC000);
      chk("asr_c", 16'(fc[0]), 16'h1);
      issue(4'd2, 3'd2, 16'h8001, 0, 0, 0, n);
      issue(4'd7, 3'd2, 16'h0, 4, 0, 0, n);
      issue(4'd2, 3'd3, 16'h5A5A, 0, 0, 0, n);
      chk("hold_wait", 16'(n), 16'd3);
      rd(3);
      chk("hold_ld", rda[0], 16'h5A5A);
      rd(2);
      chk("hold_ror", rda[0], 16'h1800);
      issue(4'd2, 3'd3, 16'h0, 0, 0, 0, n);
      issue(4'd5, 3'd3, 16'h0, 3, 1, 0, n);
      wait_done(n);
      chk("shr_latency", 16'(n), 16'd3);
      rd(3);
      chk("shr_fill", rda[0], 16'hE000);
      issue(4'd2, 3'd3, 16'h0001, 0, 0, 0, n);
      issue(4'd6, 3'd3, 16'h0, 2, 0, 1, n);
      wait_done(n);
      rd(3);
      chk("shl_fill", rda[0], 16'h0007);
      issue(4'd2, 3'd6, 16'h1234, 0, 0, 0, n);
      chk("oor_done", 16'(dn[0]), 16'h1);
      rd(6);
      chk("oor_read", rda[0], 16'h0);
      issue(4'd2, 3'd1, 16'h1234, 0, 0, 0, n);
      issue(4'd8, 3'd1, 16'h0, 8, 0, 0, n);
      @(negedge clk);
      #1 rst = 1;
      @(negedge clk);
      #1 rst = 0;
      rd(1);
      chk("abort_val", rda[0], 16'h0);
      chk("abort_ready", 16'(rdy[0]), 16'h1);
      chk("abort_done", 16'(dn[0]), 16'h0);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         rst = $urandom_range(0, 199) == 0;
         op_valid = $urandom_range(0, 2) != 0;
         op = 4'($urandom_range(0, 15));
         addr = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: din = 16'h0;
            1: din = 16'hFFFF;
            2: din = 16'h0001;
            default: din = 16'($urandom);
         endcase
         amt = 4'($urandom_range(0, 15));
         ir = 1'($urandom);
         il = 1'($urandom);
         rd_addr_a = 3'($urandom_range(0, 7));
         rd_addr_b = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      #1 op_valid = 0; rst = 0;
      repeat (20) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end
endmodule
